// File: rtl/seg7_pkg.sv
// rtl/seg7_pkg.sv - shared segment/anode constants for the 7-segment scan controller
package seg7_pkg;

  localparam int NUM_DIGITS = 4;

  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [3:0] AN_OFF    = 4'b1111;

  // Active-low segment codes, bit 6 = a ... bit 0 = g
  localparam logic [6:0] SEG_0 = 7'b0000001;
  localparam logic [6:0] SEG_1 = 7'b1001111;
  localparam logic [6:0] SEG_2 = 7'b0010010;
  localparam logic [6:0] SEG_3 = 7'b0000110;
  localparam logic [6:0] SEG_4 = 7'b1001100;
  localparam logic [6:0] SEG_5 = 7'b0100100;
  localparam logic [6:0] SEG_6 = 7'b0100000;
  localparam logic [6:0] SEG_7 = 7'b0001111;
  localparam logic [6:0] SEG_8 = 7'b0000000;
  localparam logic [6:0] SEG_9 = 7'b0000100;

  typedef logic [3:0] bcd_t;
  typedef logic [6:0] seg_t;

endpackage

// File: rtl/bcd_7seg.sv
// rtl/bcd_7seg.sv - combinational BCD to active-low 7-segment decoder
module bcd_7seg
  import seg7_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [6:0] seg,
  output logic       an
);

  // Standalone users get a permanently enabled digit; non-decimal codes stay dark
  assign an = 1'b0;

  always_comb begin
    seg = SEG_BLANK;
    case (bcd)
      4'd0:    seg = SEG_0;
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      default: seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/seg7_scan_ctrl.sv
// rtl/seg7_scan_ctrl.sv - 4-digit multiplexed 7-segment scanner with
// frame-synchronous double-buffered value write port
module seg7_scan_ctrl
  import seg7_pkg::*;
#(
  parameter int REFRESH_DIV = 50000,
  parameter bit LZB_EN      = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wr_en,
  input  logic [15:0] wr_data,
  output logic        wr_ready,
  input  logic        blank,
  input  logic [3:0]  dp_mask,
  output logic [6:0]  seg,
  output logic        dp,
  output logic [3:0]  an,
  output logic        frame_done
);

  localparam int DIV_W = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(REFRESH_DIV - 1);

  logic [DIV_W-1:0] div_cnt;
  logic [1:0]       idx;
  logic             tick;
  logic             boundary;

  logic [15:0]      shadow;
  logic [15:0]      pend_data;
  logic             pend_full;
  logic             accept;

  logic [3:0]       cur_nib;
  logic [6:0]       dec_seg;
  logic [3:0]       lz;
  logic [6:0]       digit_seg;

  assign tick     = (div_cnt == DIV_LAST);
  assign boundary = tick && (idx == 2'd3);
  assign wr_ready = ~pend_full;
  assign accept   = wr_en && wr_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_cnt <= '0;
      idx     <= 2'd0;
    end else if (tick) begin
      div_cnt <= '0;
      idx     <= idx + 2'd1;
    end else begin
      div_cnt <= div_cnt + DIV_W'(1);
    end
  end

  // A write landing on the boundary bypasses the pending slot entirely
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shadow    <= 16'h0000;
      pend_data <= 16'h0000;
      pend_full <= 1'b0;
    end else if (boundary) begin
      if (accept) begin
        shadow <= wr_data;
      end else if (pend_full) begin
        shadow    <= pend_data;
        pend_full <= 1'b0;
      end
    end else if (accept) begin
      pend_data <= wr_data;
      pend_full <= 1'b1;
    end
  end

  assign cur_nib = shadow[{idx, 2'b00} +: 4];

  bcd_7seg u_dec (
    .bcd (cur_nib),
    .seg (dec_seg),
    .an  ()
  );

  // lz[i] set when nibble i and every nibble above it are zero
  always_comb begin
    lz    = 4'b0000;
    lz[3] = (shadow[15:12] == 4'd0);
    lz[2] = lz[3] && (shadow[11:8] == 4'd0);
    lz[1] = lz[2] && (shadow[7:4] == 4'd0);
    lz[0] = 1'b0;
  end

  assign digit_seg = (LZB_EN && lz[idx]) ? SEG_BLANK : dec_seg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      seg        <= SEG_BLANK;
      dp         <= 1'b1;
      an         <= AN_OFF;
      frame_done <= 1'b0;
    end else begin
      frame_done <= boundary;
      if (blank) begin
        seg <= SEG_BLANK;
        dp  <= 1'b1;
        an  <= AN_OFF;
      end else begin
        seg <= digit_seg;
        dp  <= ~dp_mask[idx];
        an  <= ~(4'b0001 << idx);
      end
    end
  end

endmodule

// File: doc/seg7_scan_ctrl.md
Name: seg7_scan_ctrl

Overview:
Time-multiplexed scan controller for a 4-digit common-anode 7-segment display. It accepts a 4-digit packed BCD value through a valid/ready write port and double-buffers it so digit values change only at frame boundaries. It cycles the anode select at a programmable refresh rate and decodes each digit through the existing BCD-to-segment decoder. It sits between any value-producing logic (counters, timers) and the board's display pins.

Parameters:
REFRESH_DIV, 50000, clock cycles per digit slot; legal range >= 2
DIV_W, $clog2(REFRESH_DIV), prescaler width (derived, not overridden)
LZB_EN, 1, 1 = leading-zero blanking enabled

Ports:
clk  in  1  system clock; all state on rising edge
rst  in  1  asynchronous active-high reset
wr_en  in  1  write request (valid)
wr_data  in  16  packed BCD; [3:0] = digit 0 (rightmost, an[0]), [15:12] = digit 3
wr_ready  out  1  write accepted when wr_en && wr_ready
blank  in  1  1 = all digits dark; scanning continues
dp_mask  in  4  decimal point enable per digit, active-high
seg  out  7  segments a..g, [6]=a ... [0]=g, active-low
dp  out  1  decimal point, active-low
an  out  4  anodes an3..an0, active-low, one-hot-low while scanning
frame_done  out  1  one-cycle pulse after each full 4-digit frame

Behaviour:
- Reset (async, immediate): seg=7'b1111111, dp=1, an=4'b1111, wr_ready=1, frame_done=0; prescaler=0, digit index=0, shadow=16'h0000, pending buffer empty.
- Prescaler: counts 0..REFRESH_DIV-1, then wraps to 0. tick = (count == REFRESH_DIV-1).
- Digit index: advances 0->1->2->3->0 on tick. Frame boundary = tick while index == 3.
- Write handshake:
  - wr_en && wr_ready && !boundary: wr_data -> pending; wr_ready = 0 from next cycle.
  - At boundary with pending full: pending -> shadow; wr_ready = 1 next cycle.
  - wr_en && wr_ready && boundary in the same cycle: wr_data -> shadow directly; wr_ready stays 1.
  - wr_en while wr_ready=0: ignored; no data loss of the held pending value.
- Shadow never changes mid-frame, so no tearing.
- Outputs: registered; 1-cycle latency from index/shadow/blank/dp_mask to seg/an/dp.
  - an = ~(4'b0001 << index).
  - seg = decode(shadow nibble[index]).
  - Nibble > 9 decodes to blank (7'b1111111), with the anode still driven.
  - dp = ~dp_mask[index].
- Leading-zero blanking (LZB_EN=1): digit i (i >= 1) shows seg=7'b1111111 when nibble i and all higher nibbles are 0. Digit 0 is never LZ-blanked. A blanked digit's dp still follows dp_mask.
- blank=1: an=4'b1111, seg=7'b1111111, dp=1 on the next cycle. Prescaler, index and handshake are unaffected.
- frame_done: registered pulse, high exactly the cycle after each boundary.
- Reset mid-operation: pending write is discarded, shadow returns to 0, and scanning restarts at digit 0.

Decomposition:
- Shared package seg7_pkg: SEG_BLANK = 7'b1111111, AN_OFF = 4'b1111, NUM_DIGITS = 4, and the segment-code constants for 0-9, so the decoder and the controller agree.
- One sub-module: the existing combinational bcd_7seg decoder, instantiated once on the selected nibble. Its own anode output is left unconnected; this block owns an[3:0].

Test Plan:
- Reset then release, REFRESH_DIV=4, shadow=0 -> an cycles 1110,1101,1011,0111 every 4 clks. Digit 0 seg=7'b0000001; digits 1-3 seg=7'b1111111 (LZB).
- Write 16'h1234 mid-frame -> wr_ready drops next cycle. Current frame keeps the old value. After the boundary: an=1110 shows 7'b1001100 (4), an=0111 shows 7'b1001111 (1). wr_ready=1 again, frame_done pulses once per frame.
- Write on the exact boundary cycle -> new value is displayed from the very next digit-0 slot and wr_ready never drops. A second write while wr_ready=0 is ignored.
- Nibble 4'hA in digit 2 with LZB_EN=0 -> an=1011 with seg=7'b1111111. Value 16'h0050 with LZB_EN=1 -> digit 1 shows 5, digit 2 blank, digit 3 blank.
- blank asserted for 10 cycles -> an=4'b1111 the cycle after. Index keeps advancing, and on release the display resumes at the correct digit. dp_mask=4'b0100 -> dp=0 only while an=1011.
- Assert rst mid-frame with a pending write -> an=1111 immediately (asynchronous). After release, shadow=0, wr_ready=1, and the pending value is never displayed.
